// File: rtl/main_mem_arbiter.sv
// main_mem_arbiter
// Shares the single-port main data memory between two requesters and returns
// registered read data one cycle after the grant.
//
// Ports
//   i_clk, i_rst          single clock; synchronous active-high reset
//   i_p0_req/i_p0_addr    port 0 (instruction/debug side), read only
//   o_p0_gnt              combinational grant, request consumed this cycle
//   o_p0_rvalid/rdata     registered read response, valid for one cycle
//   i_p1_req/addr/wr_en/wr_val/wr_type
//                         port 1 (load/store unit), loads and stores
//   o_p1_gnt              combinational grant
//   o_p1_rvalid/rdata     registered load response (stores give none)
//   o_mem_addr/wr_en/wr_val/wr_type  drive main_mem from the winning port
//   i_mem_val             main_mem combinational read data
//
// Access type encoding: 2'd0 byte, 2'd1 half, 2'd2 word.
//
// Configuration macro RR_ARB_EN:
//   undefined  port 1 has priority, with port 0 forced through after
//              STARVE_LIMIT consecutive denied cycles
//   defined    round-robin between the two ports; the starvation counter
//              is not built

module main_mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4,
  parameter int DATA_W       = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_p0_req,
  input  logic [DATA_W-1:0] i_p0_addr,
  output logic              o_p0_gnt,
  output logic              o_p0_rvalid,
  output logic [DATA_W-1:0] o_p0_rdata,
  input  logic              i_p1_req,
  input  logic [DATA_W-1:0] i_p1_addr,
  input  logic              i_p1_wr_en,
  input  logic [DATA_W-1:0] i_p1_wr_val,
  input  logic [1:0]        i_p1_wr_type,
  output logic              o_p1_gnt,
  output logic              o_p1_rvalid,
  output logic [DATA_W-1:0] o_p1_rdata,
  output logic [DATA_W-1:0] o_mem_addr,
  output logic              o_mem_wr_en,
  output logic [DATA_W-1:0] o_mem_wr_val,
  output logic [1:0]        o_mem_wr_type,
  input  logic [DATA_W-1:0] i_mem_val
);

  localparam logic [1:0] L_S_WORD = 2'd2;

  logic              w_p0Gnt;
  logic              w_p1Gnt;
  logic              r_p0Rvalid;
  logic              r_p1Rvalid;
  logic [DATA_W-1:0] r_p0Rdata;
  logic [DATA_W-1:0] r_p1Rdata;

`ifdef RR_ARB_EN
  typedef enum logic {PORT0 = 1'b0, PORT1 = 1'b1} port_e;
  port_e r_rrLast;

  // Remember who was granted last so a contended cycle goes to the other port.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rrLast <= PORT1;
    end else if (w_p0Gnt) begin
      r_rrLast <= PORT0;
    end else if (w_p1Gnt) begin
      r_rrLast <= PORT1;
    end
  end
`else
  logic [CNT_W-1:0] r_starveCnt;

  // Count consecutive cycles port 0 has been waiting; saturates at the limit,
  // and any grant or dropped request starts the count again.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_starveCnt <= '0;
    end else if (i_p0_req && !w_p0Gnt) begin
      if (r_starveCnt != CNT_W'(STARVE_LIMIT)) begin
        r_starveCnt <= r_starveCnt + 1'b1;
      end
    end else begin
      r_starveCnt <= '0;
    end
  end
`endif

  // Pick at most one winner per cycle; nothing is granted while in reset.
  always_comb begin
    w_p0Gnt = 1'b0;
    w_p1Gnt = 1'b0;
    if (!i_rst) begin
      if (i_p0_req && i_p1_req) begin
`ifdef RR_ARB_EN
        if (r_rrLast == PORT1) begin
          w_p0Gnt = 1'b1;
        end else begin
          w_p1Gnt = 1'b1;
        end
`else
        if (r_starveCnt == CNT_W'(STARVE_LIMIT)) begin
          w_p0Gnt = 1'b1;
        end else begin
          w_p1Gnt = 1'b1;
        end
`endif
      end else begin
        w_p0Gnt = i_p0_req;
        w_p1Gnt = i_p1_req;
      end
    end
  end

  // Steer the memory from the winner; an idle memory sees address 0 and no write.
  always_comb begin
    o_mem_addr    = '0;
    o_mem_wr_en   = 1'b0;
    o_mem_wr_val  = '0;
    o_mem_wr_type = L_S_WORD;
    if (w_p1Gnt) begin
      o_mem_addr    = i_p1_addr;
      o_mem_wr_en   = i_p1_wr_en;
      o_mem_wr_val  = i_p1_wr_val;
      o_mem_wr_type = i_p1_wr_type;
    end else if (w_p0Gnt) begin
      o_mem_addr    = i_p0_addr;
    end
  end

  // Capture read data for granted reads; rdata holds between responses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_p0Rvalid <= 1'b0;
      r_p1Rvalid <= 1'b0;
      r_p0Rdata  <= '0;
      r_p1Rdata  <= '0;
    end else begin
      r_p0Rvalid <= w_p0Gnt;
      r_p1Rvalid <= w_p1Gnt && !i_p1_wr_en;
      if (w_p0Gnt) begin
        r_p0Rdata <= i_mem_val;
      end
      if (w_p1Gnt && !i_p1_wr_en) begin
        r_p1Rdata <= i_mem_val;
      end
    end
  end

  // A response already in flight when reset rises is suppressed immediately.
  assign o_p0_rvalid = r_p0Rvalid && !i_rst;
  assign o_p1_rvalid = r_p1Rvalid && !i_rst;
  assign o_p0_rdata  = r_p0Rdata;
  assign o_p1_rdata  = r_p1Rdata;
  assign o_p0_gnt    = w_p0Gnt;
  assign o_p1_gnt    = w_p1Gnt;

endmodule

// File: tb/tb_main_mem_arbiter.sv
// tb_main_mem_arbiter
// Drives main_mem_arbiter with directed and random traffic against a small
// word-array memory, predicts grants and read responses from the arbitration
// rules, and checks responses through a scoreboard queue per port.

module tb_main_mem_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        p0Req = 1'b0;
  logic [31:0] p0Addr = '0;
  logic        p0Gnt;
  logic        p0Rvalid;
  logic [31:0] p0Rdata;
  logic        p1Req = 1'b0;
  logic [31:0] p1Addr = '0;
  logic        p1WrEn = 1'b0;
  logic [31:0] p1WrVal = '0;
  logic [1:0]  p1WrType = 2'd2;
  logic        p1Gnt;
  logic        p1Rvalid;
  logic [31:0] p1Rdata;
  logic [31:0] memAddr;
  logic        memWrEn;
  logic [31:0] memWrVal;
  logic [1:0]  memWrType;
  logic [31:0] memVal;

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] envMem[256];
  logic [31:0] refMem[256];
  logic [31:0] last0 = '0;
  logic [31:0] last1 = '0;
  bit          inRst = 1'b1;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          denied = 0;
  int          rrLast = 1;

  always #5 clk = ~clk;

  main_mem_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(4), .DATA_W(32)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_p0_req(p0Req), .i_p0_addr(p0Addr), .o_p0_gnt(p0Gnt),
    .o_p0_rvalid(p0Rvalid), .o_p0_rdata(p0Rdata),
    .i_p1_req(p1Req), .i_p1_addr(p1Addr), .i_p1_wr_en(p1WrEn),
    .i_p1_wr_val(p1WrVal), .i_p1_wr_type(p1WrType), .o_p1_gnt(p1Gnt),
    .o_p1_rvalid(p1Rvalid), .o_p1_rdata(p1Rdata),
    .o_mem_addr(memAddr), .o_mem_wr_en(memWrEn), .o_mem_wr_val(memWrVal),
    .o_mem_wr_type(memWrType), .i_mem_val(memVal)
  );

  // Merge a store into a memory word: 0 byte, 1 half, 2 word.
  function automatic logic [31:0] mergeWord(input logic [31:0] old, input logic [31:0] val,
                                            input logic [1:0] t, input logic [1:0] lane);
    logic [31:0] r;
    r = old;
    case (t)
      2'd0:    r[{lane, 3'b000} +: 8] = val[7:0];
      2'd1:    if (lane[1]) r[31:16] = val[15:0]; else r[15:0] = val[15:0];
      default: r = val;
    endcase
    return r;
  endfunction

  // Memory environment: combinational read, write on the clock edge.
  assign memVal = envMem[memAddr[9:2]];
  always @(posedge clk) begin
    cyc++;
    if (memWrEn) envMem[memAddr[9:2]] = mergeWord(envMem[memAddr[9:2]], memWrVal, memWrType, memAddr[1:0]);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle of stimulus; predicts the winner and queues the expected response.
  task automatic applyStimulus(input bit r, input bit q0r, input logic [31:0] a0,
                               input bit q1r, input logic [31:0] a1, input bit wr,
                               input logic [31:0] wv, input logic [1:0] wt, output int win);
    @(posedge clk);
    #1;
    rst = r; p0Req = q0r; p0Addr = a0;
    p1Req = q1r; p1Addr = a1; p1WrEn = wr; p1WrVal = wv; p1WrType = wt;
    if (r) begin
      q0.delete();
      q1.delete();
    end
    @(negedge clk);
    win = -1;
    if (r) begin
      denied = 0;
      rrLast = 1;
    end else if (q0r && q1r) begin
`ifdef RR_ARB_EN
      win = (rrLast == 1) ? 0 : 1;
`else
      win = (denied == LIMIT) ? 0 : 1;
`endif
    end else if (q0r) begin
      win = 0;
    end else if (q1r) begin
      win = 1;
    end
    checkOutput("p0_gnt", {31'b0, p0Gnt}, {31'b0, win == 0});
    checkOutput("p1_gnt", {31'b0, p1Gnt}, {31'b0, win == 1});
    if (win == 0) begin
      checkOutput("mem_addr_p0", memAddr, a0);
      checkOutput("mem_wr_en_p0", {31'b0, memWrEn}, 32'd0);
      checkOutput("mem_type_p0", {30'b0, memWrType}, 32'd2);
      q0.push_back('{due: cyc + 1, data: refMem[a0[9:2]]});
      rrLast = 0;
    end else if (win == 1) begin
      checkOutput("mem_addr_p1", memAddr, a1);
      checkOutput("mem_wr_en_p1", {31'b0, memWrEn}, {31'b0, wr});
      if (wr) begin
        checkOutput("mem_wr_val", memWrVal, wv);
        checkOutput("mem_type_p1", {30'b0, memWrType}, {30'b0, wt});
        refMem[a1[9:2]] = mergeWord(refMem[a1[9:2]], wv, wt, a1[1:0]);
      end else begin
        q1.push_back('{due: cyc + 1, data: refMem[a1[9:2]]});
      end
      rrLast = 1;
    end else begin
      checkOutput("mem_addr_idle", memAddr, 32'd0);
      checkOutput("mem_wr_en_idle", {31'b0, memWrEn}, 32'd0);
    end
    if (!r) denied = (q0r && win != 0) ? ((denied < LIMIT) ? denied + 1 : LIMIT) : 0;
  endtask

  // Response monitor: pops the expected entry due this cycle, otherwise
  // requires rvalid low and rdata unchanged.
  task automatic monPort(input int p, input logic rv, input logic [31:0] rd);
    exp_t e;
    bit   has;
    has = 1'b0;
    if (p == 0 && q0.size() > 0 && q0[0].due == cyc) begin has = 1'b1; e = q0.pop_front(); end
    if (p == 1 && q1.size() > 0 && q1[0].due == cyc) begin has = 1'b1; e = q1.pop_front(); end
    checkOutput(p == 0 ? "p0_rvalid" : "p1_rvalid", {31'b0, rv}, {31'b0, has});
    if (has) begin
      checkOutput(p == 0 ? "p0_rdata" : "p1_rdata", rd, e.data);
      if (p == 0) last0 = e.data; else last1 = e.data;
    end else begin
      checkOutput(p == 0 ? "p0_rdata_hold" : "p1_rdata_hold", rd, p == 0 ? last0 : last1);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      checkOutput("p0_rvalid_rst", {31'b0, p0Rvalid}, 32'd0);
      checkOutput("p1_rvalid_rst", {31'b0, p1Rvalid}, 32'd0);
      inRst = 1'b1;
    end else begin
      if (inRst) begin
        last0 = '0;
        last1 = '0;
        inRst = 1'b0;
      end
      monPort(0, p0Rvalid, p0Rdata);
      monPort(1, p1Rvalid, p1Rdata);
    end
  end

  initial begin
    int          win;
    bit          pend0, pend1, wr, rr;
    logic [31:0] a0, a1, wv;
    logic [1:0]  wt, lane;
    for (int i = 0; i < 256; i++) begin
      envMem[i] = $urandom;
      refMem[i] = envMem[i];
    end
    envMem[4] = 32'hDEADBEEF; refMem[4] = 32'hDEADBEEF;
    envMem[8] = 32'hAABBCCDD; refMem[8] = 32'hAABBCCDD;

    // Reset with both ports requesting.
    repeat (2) applyStimulus(1, 1, 32'h0, 1, 32'h4, 0, 0, 2'd2, win);
    // Single load, then store-half / load at the same address.
    applyStimulus(0, 0, 0, 1, 32'h10, 0, 0, 2'd2, win);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 2'd2, win);
    applyStimulus(0, 0, 0, 1, 32'h20, 1, 32'h00001234, 2'd1, win);
    applyStimulus(0, 0, 0, 1, 32'h20, 0, 0, 2'd2, win);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 2'd2, win);
    // Continuous contention.
    repeat (12) applyStimulus(0, 1, 32'h8, 1, 32'hC, 0, 0, 2'd2, win);
    // Port 0 read followed immediately by reset.
    applyStimulus(0, 1, 32'h10, 0, 0, 0, 0, 2'd2, win);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 2'd2, win);
    repeat (6) applyStimulus(0, 1, 32'h14, 1, 32'h18, 0, 0, 2'd2, win);

    // Random traffic with requests held until granted.
    pend0 = 0; pend1 = 0; a0 = 0; a1 = 0; wr = 0; wv = 0; wt = 2'd2;
    for (int n = 0; n < 500; n++) begin
      if (!pend0 && $urandom_range(0, 9) < 6) begin
        pend0 = 1;
        a0 = 32'($urandom_range(0, 15)) << 2;
      end
      if (!pend1 && $urandom_range(0, 9) < 6) begin
        pend1 = 1;
        wr = 1'($urandom_range(0, 1));
        wt = 2'($urandom_range(0, 2));
        lane = (wt == 2'd2) ? 2'd0 : (wt == 2'd1) ? {1'($urandom_range(0, 1)), 1'b0} : 2'($urandom_range(0, 3));
        a1 = (32'($urandom_range(0, 15)) << 2) | {30'b0, lane};
        wv = $urandom;
      end
      rr = ($urandom_range(0, 49) == 0);
      applyStimulus(rr, pend0, a0, pend1, a1, wr, wv, wt, win);
      if (rr) begin
        pend0 = 0;
        pend1 = 0;
      end else begin
        if (win == 0) pend0 = 0;
        if (win == 1) pend1 = 0;
      end
    end
    repeat (2) applyStimulus(0, 0, 0, 0, 0, 0, 0, 2'd2, win);
    checkOutput("q0_drained", 32'(q0.size()), 32'd0);
    checkOutput("q1_drained", 32'(q1.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
